// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the execute-pipeline hazard controller: shadow entry layout,
// forwarding-select encoding, sequencer states and the register hazard match.
package cpu_ctrl_pkg;

    // Shadow register ids are stored at a fixed width so the struct is parameter-free;
    // the top zero-extends its RID_W-wide ids (supports up to 256 registers).
    localparam int HZ_ID_W = 8;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic               valid;
        logic [HZ_ID_W-1:0] ra_id;
        logic [HZ_ID_W-1:0] rb_id;
        logic               use_rb;
        logic [HZ_ID_W-1:0] reg_dest;
        logic               reg_write;
        logic               mem_read;
    } hz_entry_t;

    function automatic logic hz_hit(
        input logic [HZ_ID_W-1:0] src,
        input logic               valid,
        input logic               reg_write,
        input logic [HZ_ID_W-1:0] dest,
        input logic               r0_zero
    );
        return valid & reg_write & (src == dest) & ~(r0_zero & (src == '0));
    endfunction

endpackage

// File: rtl/cpu_fwd_sel.sv
// Forwarding select for one EX operand: EX/MEM result beats MEM/WB result,
// and a load still in MEM cannot forward (its data is not ready yet).
module cpu_fwd_sel
    import cpu_ctrl_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [HZ_ID_W-1:0] src_id,
    input  logic               src_used,
    input  logic               mem_valid,
    input  logic               mem_reg_write,
    input  logic               mem_mem_read,
    input  logic [HZ_ID_W-1:0] mem_dest,
    input  logic               wb_valid,
    input  logic               wb_reg_write,
    input  logic [HZ_ID_W-1:0] wb_dest,
    output logic [1:0]         sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = hz_hit(src_id, mem_valid, mem_reg_write, mem_dest, R0_ZERO) & ~mem_mem_read;
        wb_hit  = hz_hit(src_id, wb_valid, wb_reg_write, wb_dest, R0_ZERO);
        sel     = FWD_REG;
        if (src_used) begin
            if (mem_hit) begin
                sel = FWD_EXMEM;
            end else if (wb_hit) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Execute-pipeline sequencer: shadow EX/MEM/WB control, load-use stall, branch flush,
// data-memory freeze and operand forwarding selects.
module cpu_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  bit R0_ZERO  = 1'b1,
    localparam int RID_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RID_W-1:0] id_ra_id,
    input  logic [RID_W-1:0] id_rb_id,
    input  logic             id_use_rb,
    input  logic [RID_W-1:0] id_reg_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             mem_branch_tkn,
    input  logic             dmem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel
);

    hz_entry_t ex_reg;
    hz_entry_t mem_reg;
    hz_entry_t wb_reg;
    hz_entry_t id_entry;
    hz_state_e state_reg;

    logic load_use;
    logic freeze_int;
    logic flush_int;

    logic [HZ_ID_W-1:0] src_id   [2];
    logic               src_used [2];
    logic [1:0]         sel_v    [2];

    always_comb begin
        id_entry = '{
            valid:     id_valid,
            ra_id:     HZ_ID_W'(id_ra_id),
            rb_id:     HZ_ID_W'(id_rb_id),
            use_rb:    id_use_rb,
            reg_dest:  HZ_ID_W'(id_reg_dest),
            reg_write: id_reg_write,
            mem_read:  id_mem_read
        };
    end

    always_comb begin
        load_use = id_valid & ex_reg.mem_read &
                   (hz_hit(id_entry.ra_id, ex_reg.valid, ex_reg.reg_write, ex_reg.reg_dest, R0_ZERO) |
                    (id_use_rb &
                     hz_hit(id_entry.rb_id, ex_reg.valid, ex_reg.reg_write, ex_reg.reg_dest, R0_ZERO)));

        // Once waiting, the busy signal alone holds the pipe; MEM is frozen anyway.
        freeze_int = (state_reg == MEM_WAIT) ? dmem_busy : (dmem_busy & mem_reg.valid);
        flush_int  = ~freeze_int & mem_branch_tkn & mem_reg.valid;
    end

    assign freeze    = freeze_int;
    assign flush     = flush_int;
    assign stall_if  = freeze_int | (~flush_int & load_use);
    assign stall_id  = freeze_int | (~flush_int & load_use);
    assign bubble_ex = ~freeze_int & ~flush_int & load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg  <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else if (!freeze_int) begin
            wb_reg <= mem_reg;
            if (flush_int) begin
                ex_reg  <= '0;
                mem_reg <= '0;
            end else if (load_use) begin
                ex_reg  <= '0;
                mem_reg <= ex_reg;
            end else begin
                ex_reg  <= id_entry;
                mem_reg <= ex_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN:      if (dmem_busy && mem_reg.valid) state_reg <= MEM_WAIT;
                MEM_WAIT: if (!dmem_busy) state_reg <= RUN;
                default:  state_reg <= RUN;
            endcase
        end
    end

    always_comb begin
        src_id[0]   = ex_reg.ra_id;
        src_used[0] = ex_reg.valid;
        src_id[1]   = ex_reg.rb_id;
        src_used[1] = ex_reg.valid & ex_reg.use_rb;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            cpu_fwd_sel #(
                .R0_ZERO(R0_ZERO)
            ) u_fwd_sel (
                .src_id       (src_id[gi]),
                .src_used     (src_used[gi]),
                .mem_valid    (mem_reg.valid),
                .mem_reg_write(mem_reg.reg_write),
                .mem_mem_read (mem_reg.mem_read),
                .mem_dest     (mem_reg.reg_dest),
                .wb_valid     (wb_reg.valid),
                .wb_reg_write (wb_reg.reg_write),
                .wb_dest      (wb_reg.reg_dest),
                .sel          (sel_v[gi])
            );
        end
    endgenerate

    assign fwd_a_sel = sel_v[0];
    assign fwd_b_sel = sel_v[1];

    // Source ids are only needed while an entry is in EX; later stages keep them for symmetry.
    logic unused_fields;
    assign unused_fields = ^{mem_reg.ra_id, mem_reg.rb_id, mem_reg.use_rb,
                             wb_reg.ra_id, wb_reg.rb_id, wb_reg.use_rb, wb_reg.mem_read};

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl: forwarding, load-use, R0, flush, freeze and reset scenarios.
module tb_cpu_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_ra_id = '0;
    logic [4:0] id_rb_id = '0;
    logic       id_use_rb = 1'b0;
    logic [4:0] id_reg_dest = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       mem_branch_tkn = 1'b0;
    logic       dmem_busy = 1'b0;
    logic       stall_if, stall_id, bubble_ex, flush, freeze;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int checks = 0;
    int failures = 0;

    // {stall_if, stall_id, bubble_ex, flush, freeze, fwd_a_sel, fwd_b_sel}
    logic [8:0] outv;
    assign outv = {stall_if, stall_id, bubble_ex, flush, freeze, fwd_a_sel, fwd_b_sel};

    always #5 clk = ~clk;

    cpu_hazard_ctrl #(
        .NUM_REGS(32),
        .R0_ZERO (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ra_id      (id_ra_id),
        .id_rb_id      (id_rb_id),
        .id_use_rb     (id_use_rb),
        .id_reg_dest   (id_reg_dest),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .mem_branch_tkn(mem_branch_tkn),
        .dmem_busy     (dmem_busy),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .bubble_ex     (bubble_ex),
        .flush         (flush),
        .freeze        (freeze),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel)
    );

    task automatic set_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                          input logic urb, input logic [4:0] dest, input logic rw, input logic mr);
        id_valid = v; id_ra_id = ra; id_rb_id = rb; id_use_rb = urb;
        id_reg_dest = dest; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic id_nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        id_nop();
        mem_branch_tkn = 1'b0;
        dmem_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        rst_n = 1'b0;
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        mem_branch_tkn = 1'b1;
        dmem_busy = 1'b1;
        @(negedge clk);
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", outv, exp_v); end
        apply_reset();
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL reset_release got=%b exp=%b", outv, exp_v); end
        $display("test_reset done");
    endtask

    task automatic test_forward();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3 <- r1,r2
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL fwd_c0 got=%b exp=%b", outv, exp_v); end
        step();
        set_id(1'b1, 5'd3, 5'd6, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4 <- r3,r6
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL fwd_c1 got=%b exp=%b", outv, exp_v); end
        step();
        set_id(1'b1, 5'd3, 5'd8, 1'b1, 5'd7, 1'b1, 1'b0);   // or r7 <- r3,r8
        exp_v = {5'b00000, 2'b01, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL fwd_exmem got=%b exp=%b", outv, exp_v); end
        step();
        id_nop();
        exp_v = {5'b00000, 2'b10, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL fwd_memwb got=%b exp=%b", outv, exp_v); end
        $display("test_forward done");
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);   // add r3 <- r1
        step();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);   // add r3 <- r1 again
        step();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);   // sub r9 <- r3,r3
        step();
        id_nop();
        exp_v = {5'b00000, 2'b01, 2'b01};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL b2b_exmem_priority got=%b exp=%b", outv, exp_v); end
        step();
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL b2b_ex_invalid got=%b exp=%b", outv, exp_v); end
        $display("test_back_to_back done");
    endtask

    task automatic test_load_use();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5 <- (r1)
        step();
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add r6 <- r5,r5
        exp_v = {5'b11100, 2'b00, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL load_use_stall got=%b exp=%b", outv, exp_v); end
        step();
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL load_use_one_cycle got=%b exp=%b", outv, exp_v); end
        step();
        id_nop();
        exp_v = {5'b00000, 2'b10, 2'b10};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL load_use_fwd got=%b exp=%b", outv, exp_v); end
        $display("test_load_use done");
    endtask

    task automatic test_r0();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // ld r0
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);   // add r2 <- r0,r0
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL r0_no_stall got=%b exp=%b", outv, exp_v); end
        step();
        id_nop();
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL r0_no_fwd_mem got=%b exp=%b", outv, exp_v); end
        step();
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL r0_no_fwd_wb got=%b exp=%b", outv, exp_v); end
        $display("test_r0 done");
    endtask

    task automatic test_flush();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);   // branch
        step();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5
        step();
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add r6 <- r5,r5
        mem_branch_tkn = 1'b1;
        exp_v = {5'b00010, 2'b00, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL flush_over_load_use got=%b exp=%b", outv, exp_v); end
        step();
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL flush_single_cycle got=%b exp=%b", outv, exp_v); end
        step();
        mem_branch_tkn = 1'b0;
        id_nop();
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL flush_killed_load got=%b exp=%b", outv, exp_v); end
        $display("test_flush done");
    endtask

    task automatic test_freeze();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);   // add r3 <- r1
        step();
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5 <- (r3)
        step();
        set_id(1'b1, 5'd3, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0);   // sub r8 <- r3,r9
        exp_v = {5'b00000, 2'b01, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL frz_pre_fwd got=%b exp=%b", outv, exp_v); end
        step();
        id_nop();
        dmem_busy = 1'b1;
        mem_branch_tkn = 1'b1;
        exp_v = {5'b11001, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (outv !== exp_v) begin failures++; $display("FAIL frz_cycle%0d got=%b exp=%b", i, outv, exp_v); end
            step();
        end
        dmem_busy = 1'b0;
        exp_v = {5'b00010, 2'b10, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL frz_flush_after got=%b exp=%b", outv, exp_v); end
        step();
        mem_branch_tkn = 1'b0;
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL frz_drained got=%b exp=%b", outv, exp_v); end
        $display("test_freeze done");
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] exp_v;
        apply_reset();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // ld r5
        step();
        id_nop();
        step();
        dmem_busy = 1'b1;
        exp_v = {5'b11001, 2'b00, 2'b00};
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL mw_enter got=%b exp=%b", outv, exp_v); end
        step();
        mem_branch_tkn = 1'b1;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL mw_hold got=%b exp=%b", outv, exp_v); end
        #2;
        rst_n = 1'b0;
        exp_v = 9'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL mw_async_reset got=%b exp=%b", outv, exp_v); end
        step();
        rst_n = 1'b1;
        mem_branch_tkn = 1'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL mw_state_run got=%b exp=%b", outv, exp_v); end
        step();
        dmem_busy = 1'b0;
        #1; checks++;
        if (outv !== exp_v) begin failures++; $display("FAIL mw_quiet got=%b exp=%b", outv, exp_v); end
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_r0();
        test_flush();
        test_freeze();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
